// File: rtl/sort_engine.sv
// sort_engine: in-place selection sort of a RAM window, ascending/descending, signed/unsigned,
// driving an external single-port synchronous RAM.
module sort_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W:0]   i_len,
  input  logic [1:0]        i_mode,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_swap_cnt,
  output logic              o_mem_rd_en,
  output logic              o_mem_wr_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_RD_I   = 4'd1;
  localparam logic [3:0] S_CAP_I  = 4'd2;
  localparam logic [3:0] S_RD_J   = 4'd3;
  localparam logic [3:0] S_CAP_J  = 4'd4;
  localparam logic [3:0] S_SWAP_I = 4'd5;
  localparam logic [3:0] S_SWAP_M = 4'd6;
  localparam logic [3:0] S_NEXT_I = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;
  localparam logic [ADDR_W:0] TWO = {{(ADDR_W-1){1'b0}}, 2'b10};

  logic [3:0]        r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   r_len;
  logic [1:0]        r_mode;
  logic [ADDR_W:0]   r_i;
  logic [ADDR_W:0]   r_j;
  logic [ADDR_W:0]   r_min_idx;
  logic [DATA_W-1:0] r_val_i;
  logic [DATA_W-1:0] r_min_val;
  logic [ADDR_W-1:0] r_swap_cnt;

  logic              w_lt;
  logic              w_gt;
  logic              w_better;
  logic              w_last_j;
  logic [ADDR_W:0]   w_min_idx;
  logic [ADDR_W-1:0] w_addr_i;
  logic [ADDR_W-1:0] w_addr_j;
  logic [ADDR_W-1:0] w_addr_m;

  assign w_lt      = r_mode[1] ? ($signed(i_mem_rdata) < $signed(r_min_val)) : (i_mem_rdata < r_min_val);
  assign w_gt      = r_mode[1] ? ($signed(i_mem_rdata) > $signed(r_min_val)) : (i_mem_rdata > r_min_val);
  assign w_better  = r_mode[0] ? w_gt : w_lt;
  assign w_last_j  = (r_j == r_len - 1'b1);
  assign w_min_idx = w_better ? r_j : r_min_idx;
  assign w_addr_i  = r_base + r_i[ADDR_W-1:0];
  assign w_addr_j  = r_base + r_j[ADDR_W-1:0];
  assign w_addr_m  = r_base + r_min_idx[ADDR_W-1:0];

  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_swap_cnt  = r_swap_cnt;
  assign o_mem_rd_en = (r_state == S_RD_I) || (r_state == S_RD_J);
  assign o_mem_wr_en = (r_state == S_SWAP_I) || (r_state == S_SWAP_M);
  assign o_mem_addr  = (r_state == S_RD_I || r_state == S_SWAP_I) ? w_addr_i :
                       (r_state == S_RD_J) ? w_addr_j :
                       (r_state == S_SWAP_M) ? w_addr_m : '0;
  assign o_mem_wdata = (r_state == S_SWAP_I) ? r_min_val :
                       (r_state == S_SWAP_M) ? r_val_i : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_len      <= '0;
      r_mode     <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_min_idx  <= '0;
      r_val_i    <= '0;
      r_min_val  <= '0;
      r_swap_cnt <= '0;
    end else if (i_abort && r_state != S_IDLE && r_state != S_DONE) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_base     <= i_base;
          r_len      <= i_len;
          r_mode     <= i_mode;
          r_swap_cnt <= '0;
          r_i        <= '0;
          r_state    <= (i_len < TWO) ? S_DONE : S_RD_I;
        end
        S_RD_I: r_state <= S_CAP_I;
        S_CAP_I: begin
          r_val_i   <= i_mem_rdata;
          r_min_val <= i_mem_rdata;
          r_min_idx <= r_i;
          r_j       <= r_i + 1'b1;
          r_state   <= S_RD_J;
        end
        S_RD_J: r_state <= S_CAP_J;
        S_CAP_J: begin
          if (w_better) begin
            r_min_val <= i_mem_rdata;
            r_min_idx <= r_j;
          end
          r_j     <= r_j + 1'b1;
          r_state <= !w_last_j ? S_RD_J : (w_min_idx != r_i) ? S_SWAP_I : S_NEXT_I;
        end
        S_SWAP_I: r_state <= S_SWAP_M;
        S_SWAP_M: begin
          r_swap_cnt <= r_swap_cnt + 1'b1;
          r_state    <= S_NEXT_I;
        end
        S_NEXT_I: begin
          r_i     <= r_i + 1'b1;
          r_state <= (r_i == r_len - TWO) ? S_DONE : S_RD_I;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sort_engine.sv
// tb_sort_engine: table-driven, hand-sequenced and randomized checks of sort_engine
// against a RAM model and an array-level selection-sort reference.
module tb_sort_engine;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       start = 0;
  logic       abort = 0;
  logic [7:0] base = 0;
  logic [8:0] len = 0;
  logic [1:0] mode = 0;
  logic       o_busy, o_done, o_mem_rd_en, o_mem_wr_en;
  logic [7:0] o_swap_cnt, o_mem_addr, o_mem_wdata;
  logic [7:0] mem_rdata = 0;
  logic [7:0] mem [256];
  logic       ld_en = 0;
  logic [7:0] ld_addr = 0;
  logic [7:0] ld_data = 0;
  logic [17:0] trace[$];
  int errs = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]      base;
    logic [8:0]      len;
    logic [1:0]      mode;
    logic [0:7][7:0] d;
    logic [0:7][7:0] e;
    int              sw;
    int              cyc;
  } vec_t;
  vec_t tv [9];
  logic [17:0] exp_tr [7];

  sort_engine #(.ADDR_W(8), .DATA_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_base(base), .i_len(len), .i_mode(mode),
    .o_busy(o_busy), .o_done(o_done), .o_swap_cnt(o_swap_cnt),
    .o_mem_rd_en(o_mem_rd_en), .o_mem_wr_en(o_mem_wr_en),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (o_mem_wr_en) mem[o_mem_addr] <= o_mem_wdata;
    if (o_mem_rd_en) mem_rdata <= mem[o_mem_addr];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic bit better(input logic [7:0] a, input logic [7:0] b, input logic [1:0] md);
    int va = md[1] ? int'($signed(a)) : int'(a);
    int vb = md[1] ? int'($signed(b)) : int'(b);
    return md[0] ? (va > vb) : (va < vb);
  endfunction

  // Selection sort on a plain array; cycle cost: 3 per outer pass, 2 per compare, 2 per swap, 1 for DONE.
  task automatic model(input logic [7:0] d[$], input logic [1:0] md,
                       output logic [7:0] s[$], output int sw, output int cyc);
    int m;
    logic [7:0] t;
    int n;
    s = d; sw = 0; n = s.size(); cyc = 1;
    for (int i = 0; i < n - 1; i++) begin
      m = i;
      for (int j = i + 1; j < n; j++) if (better(s[j], s[m], md)) m = j;
      cyc += 3 + 2 * (n - 1 - i);
      if (m != i) begin
        t = s[i]; s[i] = s[m]; s[m] = t;
        sw++; cyc += 2;
      end
    end
  endtask

  task automatic load(input logic [7:0] b, input logic [7:0] d[$]);
    foreach (d[k]) begin
      @(negedge clk);
      ld_en = 1; ld_addr = b + 8'(k); ld_data = d[k];
    end
    @(negedge clk);
    ld_en = 0;
  endtask

  task automatic run(input logic [7:0] b, input logic [8:0] n, input logic [1:0] md, input int poke,
                     output int cyc, output int rds, output int wrs, output bit ok, output bit single);
    logic [7:0] off;
    trace.delete(); rds = 0; wrs = 0; ok = 1;
    @(negedge clk);
    base = b; len = n; mode = md; start = 1;
    @(negedge clk);
    start = 0; cyc = 1;
    while (!o_done && cyc < 4000) begin
      start = (cyc == poke);
      if (cyc == poke) len = 9'd0;
      trace.push_back({o_mem_rd_en, o_mem_wr_en, o_mem_addr, o_mem_wdata});
      off = o_mem_addr - b;
      if (o_mem_rd_en) rds++;
      if (o_mem_wr_en) wrs++;
      if ((o_mem_rd_en || o_mem_wr_en) && {1'b0, off} >= n) ok = 0;
      if (o_mem_rd_en && o_mem_wr_en) ok = 0;
      if (!o_mem_wr_en && o_mem_wdata != 0) ok = 0;
      if (!o_mem_rd_en && !o_mem_wr_en && o_mem_addr != 0) ok = 0;
      @(negedge clk);
      cyc++;
    end
    start = 0;
    if (!o_done) cyc = -1;
    @(negedge clk);
    single = !o_done && !o_busy;
  endtask

  task automatic check_run(input string tag, input logic [7:0] b, input logic [1:0] md,
                           input logic [7:0] d[$], input logic [7:0] e[$],
                           input int sw, input int cyc_exp, input int poke);
    int cyc, rds, wrs, n;
    bit ok, single;
    n = d.size();
    load(b, d);
    run(b, 9'(n), md, poke, cyc, rds, wrs, ok, single);
    chk({tag, " cycles"}, cyc, cyc_exp);
    chk({tag, " swap_cnt"}, {24'd0, o_swap_cnt}, sw);
    chk({tag, " reads"}, rds, (n < 2) ? 0 : (n - 1) + n * (n - 1) / 2);
    chk({tag, " writes"}, wrs, 2 * sw);
    chk({tag, " bus_rules"}, {31'd0, ok}, 1);
    chk({tag, " done_pulse"}, {31'd0, single}, 1);
    foreach (e[k]) chk($sformatf("%s word%0d", tag, k), {24'd0, mem[b + 8'(k)]}, {24'd0, e[k]});
  endtask

  initial begin
    logic [7:0] d[$];
    logic [7:0] e[$];
    int sw, cyc, n, bad;
    logic [7:0] b;
    logic [1:0] md;

    tv[0] = '{8'h10, 9'd5, 2'b00, {8'd5, 8'd3, 8'd8, 8'd1, 8'd9, 24'd0}, {8'd1, 8'd3, 8'd5, 8'd8, 8'd9, 24'd0}, 2, 37};
    tv[1] = '{8'h10, 9'd5, 2'b01, {8'd5, 8'd3, 8'd8, 8'd1, 8'd9, 24'd0}, {8'd9, 8'd8, 8'd5, 8'd3, 8'd1, 24'd0}, 4, 41};
    tv[2] = '{8'h30, 9'd3, 2'b00, {8'd2, 8'd2, 8'd2, 40'd0}, {8'd2, 8'd2, 8'd2, 40'd0}, 0, 13};
    tv[3] = '{8'h50, 9'd4, 2'b10, {8'h7F, 8'h80, 8'h00, 8'hFF, 32'd0}, {8'h80, 8'hFF, 8'h00, 8'h7F, 32'd0}, 2, 26};
    tv[4] = '{8'h50, 9'd4, 2'b00, {8'h7F, 8'h80, 8'h00, 8'hFF, 32'd0}, {8'h00, 8'h7F, 8'h80, 8'hFF, 32'd0}, 2, 26};
    tv[5] = '{8'h20, 9'd0, 2'b00, 64'd0, 64'd0, 0, 1};
    tv[6] = '{8'h20, 9'd1, 2'b00, {8'hAA, 56'd0}, {8'hAA, 56'd0}, 0, 1};
    tv[7] = '{8'h40, 9'd2, 2'b00, {8'd1, 8'd0, 48'd0}, {8'd0, 8'd1, 48'd0}, 1, 8};
    tv[8] = '{8'hFE, 9'd3, 2'b00, {8'd3, 8'd1, 8'd2, 40'd0}, {8'd1, 8'd2, 8'd3, 40'd0}, 2, 17};
    exp_tr = '{{2'b10, 8'h40, 8'h00}, 18'd0, {2'b10, 8'h41, 8'h00}, 18'd0,
               {2'b01, 8'h40, 8'h00}, {2'b01, 8'h41, 8'h01}, 18'd0};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {o_busy, o_done, o_mem_rd_en, o_mem_wr_en, o_swap_cnt, o_mem_addr, o_mem_wdata}, 0);
    rst_n = 1;
    @(negedge clk);

    for (int k = 0; k < 9; k++) begin
      d.delete(); e.delete();
      for (int m = 0; m < int'(tv[k].len); m++) begin
        d.push_back(tv[k].d[m]);
        e.push_back(tv[k].e[m]);
      end
      check_run($sformatf("vec%0d", k), tv[k].base, tv[k].mode, d, e, tv[k].sw, tv[k].cyc, 0);
      if (k == 7) begin
        chk("len2 trace_len", trace.size(), 7);
        for (int t = 0; t < 7 && t < trace.size(); t++)
          chk($sformatf("len2 trace%0d", t), {14'd0, trace[t]}, {14'd0, exp_tr[t]});
      end
    end

    // start pulses while busy must not disturb the run in progress
    d = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd9};
    e = '{8'd1, 8'd3, 8'd5, 8'd8, 8'd9};
    check_run("busy_start", 8'h60, 2'b00, d, e, 2, 37, 3);

    // abort in the first RD_J
    load(8'h10, d);
    @(negedge clk);
    base = 8'h10; len = 9'd5; mode = 2'b00; start = 1;
    @(negedge clk);
    start = 0; n = 0;
    while (!(o_mem_rd_en && o_mem_addr == 8'h11) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort reach_rd_j", {31'd0, n < 50}, 1);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort busy", {31'd0, o_busy}, 0);
    bad = 0;
    repeat (10) begin
      if (o_mem_rd_en || o_mem_wr_en || o_done || o_busy) bad++;
      @(negedge clk);
    end
    chk("abort quiet", bad, 0);
    chk("abort ram_untouched", {mem[8'h10], mem[8'h13]}, {8'd5, 8'd1});

    // asynchronous reset mid-run, then a clean run
    load(8'h10, d);
    @(negedge clk);
    base = 8'h10; len = 9'd5; mode = 2'b00; start = 1;
    @(negedge clk);
    start = 0;
    repeat (14) @(negedge clk);
    chk("midrun swap_cnt_seen", {31'd0, o_swap_cnt != 0}, 1);
    rst_n = 0;
    #1;
    chk("midrun reset_outputs", {o_busy, o_done, o_mem_rd_en, o_mem_wr_en, o_swap_cnt, o_mem_addr, o_mem_wdata}, 0);
    @(negedge clk);
    rst_n = 1;
    d = '{8'h7F, 8'h80, 8'h00, 8'hFF};
    e = '{8'h80, 8'hFF, 8'h00, 8'h7F};
    check_run("after_reset", 8'h10, 2'b10, d, e, 2, 26, 0);

    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(0, 12);
      b = 8'($urandom);
      md = 2'($urandom);
      d.delete();
      repeat (n) d.push_back(8'(($urandom % 6) * 50));
      model(d, md, e, sw, cyc);
      check_run($sformatf("rand%0d", r), b, md, d, e, sw, cyc, 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
